serial_adder_4bit: RTL and testbench

SERIAL_ADDER_4BIT -- requirements
Module: serial_adder_4bit

---
 rtl/serial_adder_pkg.sv | 16 +
 rtl/Full_adder.sv | 14 +
 rtl/serial_adder_4bit.sv | 109 ++++++++++
 tb/tb_serial_adder_4bit.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder.
//   state_t   : FSM state encoding (IDLE, SHIFT, DONE)
//   DEF_WIDTH : default operand width
//   cnt_w()   : bit-counter width for a given operand width, $clog2(w+1)
//   CNT_W     : bit-counter width at the default operand width
package serial_adder_pkg;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  localparam int DEF_WIDTH = 4;

  function automatic int cnt_w(input int w);
    return $clog2(w + 1);
  endfunction

  localparam int CNT_W = cnt_w(DEF_WIDTH);
endpackage

// File: rtl/Full_adder.sv
// One-bit full adder used as the serial adder's datapath.
//   A, B, Cin : operand bits and carry-in
//   Sum       : A ^ B ^ Cin
//   Cout      : majority(A, B, Cin)
module Full_adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (A & Cin) | (B & Cin);
endmodule

// File: rtl/serial_adder_4bit.sv
// Bit-serial adder, LSB first, one full-add per clock with a carry flop
// between bits.
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request; A/B/Cin sampled when not busy
//   A, B, Cin  : operands and carry-in
//   sub        : (SERIAL_ADDER_SUB_EN only) 1 = compute A-B-Cin
//   busy       : high while bits are being processed (SHIFT)
//   done       : one-cycle pulse (DONE); Sum/Cout valid from here
//   Sum, Cout  : registered result / carry-out (borrow-out in sub mode)
// Build option: define SERIAL_ADDER_SUB_EN to add the subtract mode.
module serial_adder_4bit
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);
  localparam int CW = cnt_w(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             accept, last;
  logic             fa_s, fa_co;
  logic             inv_in, inv_out;

  // Subtract is A + ~B + ~Cin; the final carry is inverted to a borrow.
`ifdef SERIAL_ADDER_SUB_EN
  logic sub_r;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)      sub_r <= 1'b0;
    else if (accept) sub_r <= sub;
  assign inv_in  = sub;
  assign inv_out = sub_r;
`else
  assign inv_in  = 1'b0;
  assign inv_out = 1'b0;
`endif

  // Starts arriving mid-operation are dropped; DONE accepts for zero-gap reuse.
  assign accept = start && (state != SHIFT);
  assign last   = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE:  if (start) state_nxt = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  Full_adder u_fa (
    .A   (a_sh[0]),
    .B   (b_sh[0]),
    .Cin (carry),
    .Sum (fa_s),
    .Cout(fa_co)
  );

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      Sum   <= '0;
      Cout  <= 1'b0;
    end else if (accept) begin
      a_sh  <= A;
      b_sh  <= B ^ {WIDTH{inv_in}};
      carry <= Cin ^ inv_in;
      cnt   <= '0;
    end else if (state == SHIFT) begin
      a_sh  <= a_sh >> 1;
      b_sh  <= b_sh >> 1;
      carry <= fa_co;
      // Sum bits enter at the MSB so bit 0 lands at the LSB after WIDTH shifts.
      Sum   <= {fa_s, Sum[WIDTH-1:1]};
      cnt   <= cnt + CW'(1);
      if (last) Cout <= fa_co ^ inv_out;
    end
endmodule

// File: tb/tb_serial_adder_4bit.sv
// Self-checking bench for serial_adder_4bit: directed corner cases plus
// randomized operations against an arithmetic reference model.
// Edge 0 of an operation is the edge after which start is presented.
module tb_serial_adder_4bit;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst_n, start, Cin;
  logic [W-1:0] A, B, Sum;
  logic         busy, done, Cout;
`ifdef SERIAL_ADDER_SUB_EN
  logic         sub;
`endif

  int n_chk = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  serial_adder_4bit #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .A    (A),
    .B    (B),
    .Cin  (Cin),
`ifdef SERIAL_ADDER_SUB_EN
    .sub  (sub),
`endif
    .busy (busy),
    .done (done),
    .Sum  (Sum),
    .Cout (Cout)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
    end
  endtask

  // {carry/borrow, result} from plain integer arithmetic.
  function automatic logic [W:0] model(input int a, input int b, input int ci, input bit s);
    int r;
    if (s) begin
      r = a - b - ci;
      return {(r < 0), r[W-1:0]};
    end
    r = a + b + ci;
    return r[W:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one operation; disturb re-pulses start with new operands mid-op.
  task automatic op(input string tag, input int a, input int b, input int ci,
                    input bit s, input bit disturb);
    logic [W:0] e;
    int lat = 0;
    int nb  = 0;
    e = model(a, b, ci, s);
    A = W'(a); B = W'(b); Cin = ci[0]; start = 1'b1;
`ifdef SERIAL_ADDER_SUB_EN
    sub = s;
`endif
    do begin
      tick();
      lat++;
      start = (disturb && lat == 2);
      if (disturb && lat == 2) begin A = '1; B = '1; end
      if (busy) nb++;
    end while (!done && lat < 4 * W + 8);
    chk({tag, " lat"},  lat, W + 1);
    chk({tag, " busy"}, nb, W);
    chk({tag, " sum"},  Sum, e[W-1:0]);
    chk({tag, " cout"}, Cout, e[W]);
  endtask

  initial begin
    int first, second, seen;
    bit s;
    rst_n = 1'b0; start = 1'b0; A = '0; B = '0; Cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    sub = 1'b0;
`endif
    repeat (2) tick();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst sum",  Sum, 0);
    chk("rst cout", Cout, 0);
    rst_n = 1'b1;
    tick();

    op("9+8", 9, 8, 0, 0, 0);

    op("F+0+1", 15, 0, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("hold sum",  Sum, 0);
      chk("hold cout", Cout, 1);
      chk("hold done", done, 0);
    end

    op("3+4 ign", 3, 4, 0, 0, 1);
    tick();
    chk("ign no restart", busy, 0);

    // Reset aborts an operation in flight.
    A = 4'h5; B = 4'h6; Cin = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort done", done, 0);
    chk("abort sum",  Sum, 0);
    chk("abort cout", Cout, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      tick();
      if (done) seen++;
    end
    chk("abort no done", seen, 0);
    op("1+1", 1, 1, 0, 0, 0);
    tick();

    // Back-to-back: start held high through DONE.
    A = 4'h2; B = 4'h2; Cin = 1'b0; start = 1'b1;
    first = -1; second = -1;
    for (int i = 1; i <= 30 && second < 0; i++) begin
      tick();
      if (done) begin
        if (first < 0) first = i;
        else           second = i;
      end
    end
    start = 1'b0;
    chk("b2b first", first, W + 1);
    chk("b2b gap",   second - first, W + 1);
    chk("b2b sum",   Sum, 4);
    chk("b2b cout",  Cout, 0);
    tick();

`ifdef SERIAL_ADDER_SUB_EN
    op("3-5", 3, 5, 0, 1, 0);
    op("7-2-1", 7, 2, 1, 1, 0);
`endif

    for (int k = 0; k < 40; k++) begin
      s = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
      s = bit'($urandom_range(0, 1));
`endif
      op("rand", int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
         int'($urandom_range(0, 1)), s, bit'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) tick();
    end

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
